// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle between a conversion requester and bin2bcd_seq.
interface bin2bcd_seq_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;

  modport master (output start, in, input busy, done, bcd, overflow);
  modport slave  (input start, in, output busy, done, bcd, overflow);
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter: one input bit per clock,
// one shared bank of add-3 cells, start/busy/done handshake and overflow flag.
module bin2bcd_seq #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic         clk,
  input  logic         rst,
  bin2bcd_seq_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned TW = BW + WIDTH;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_nx;
  logic [WIDTH-1:0] bin_sr, bin_sr_nx;
  logic [BW-1:0]   dig, dig_nx;
  logic [BW-1:0]   dig_adj;
  logic [TW:0]     shifted;
  logic            ovf_acc, ovf_acc_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            busy_q, busy_nx;
  logic            done_q, done_nx;
  logic [BW-1:0]   bcd_q, bcd_nx;
  logic            ovf_q, ovf_nx;

  // Add-3 correction on every scratch digit, then one-bit left shift of {digits, bin_sr}.
  always_comb begin
    dig_adj = dig;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (dig[4*k +: 4] >= 4'd5) dig_adj[4*k +: 4] = dig[4*k +: 4] + 4'd3;
    end
    shifted = {dig_adj, bin_sr, 1'b0};
  end

  always_comb begin
    state_nx   = state;
    bin_sr_nx  = bin_sr;
    dig_nx     = dig;
    ovf_acc_nx = ovf_acc;
    cnt_nx     = cnt;
    bcd_nx     = bcd_q;
    ovf_nx     = ovf_q;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          bin_sr_nx  = bus.in;
          dig_nx     = '0;
          ovf_acc_nx = 1'b0;
          cnt_nx     = CW'(WIDTH);
          state_nx   = SHIFT;
        end else begin
          state_nx = IDLE;
        end
      end
      SHIFT: begin
        dig_nx     = shifted[TW-1:WIDTH];
        bin_sr_nx  = shifted[WIDTH-1:0];
        ovf_acc_nx = ovf_acc | shifted[TW];
        cnt_nx     = cnt - CW'(1);
        // Last bit: publish straight from the shifter so outputs never see scratch values.
        if (cnt == CW'(1)) begin
          bcd_nx   = shifted[TW-1:WIDTH];
          ovf_nx   = ovf_acc | shifted[TW];
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx == SHIFT);
    done_nx = (state_nx == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bin_sr  <= '0;
      dig     <= '0;
      ovf_acc <= 1'b0;
      cnt     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      bin_sr  <= bin_sr_nx;
      dig     <= dig_nx;
      ovf_acc <= ovf_acc_nx;
      cnt     <= cnt_nx;
      busy_q  <= busy_nx;
      done_q  <= done_nx;
      bcd_q   <= bcd_nx;
      ovf_q   <= ovf_nx;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq across several WIDTH/DIGITS configurations,
// compared against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  bin2bcd_seq_if #(.WIDTH(16), .DIGITS(5)) b16 ();
  bin2bcd_seq_if #(.WIDTH(6),  .DIGITS(2)) b6 ();
  bin2bcd_seq_if #(.WIDTH(8),  .DIGITS(2)) b8 ();
  bin2bcd_seq_if #(.WIDTH(1),  .DIGITS(1)) b1 ();

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u16 (.clk(clk), .rst(rst), .bus(b16));
  bin2bcd_seq #(.WIDTH(6),  .DIGITS(2)) u6  (.clk(clk), .rst(rst), .bus(b6));
  bin2bcd_seq #(.WIDTH(8),  .DIGITS(2)) u8  (.clk(clk), .rst(rst), .bus(b8));
  bin2bcd_seq #(.WIDTH(1),  .DIGITS(1)) u1  (.clk(clk), .rst(rst), .bus(b1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by division, overflow when value >= 10^digits.
  task automatic ref_bcd(input longint unsigned v, input int digits,
                         output logic [63:0] b, output logic o);
    longint unsigned p = 1;
    b = '0;
    for (int k = 0; k < digits; k++) begin
      b[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    o = (v >= p);
  endtask

  task automatic drive(input int sel, input logic s, input longint unsigned v);
    case (sel)
      0: begin b16.start = s; b16.in = 16'(v); end
      1: begin b6.start  = s; b6.in  = 6'(v);  end
      2: begin b8.start  = s; b8.in  = 8'(v);  end
      default: begin b1.start = s; b1.in = 1'(v); end
    endcase
  endtask

  function automatic logic get_done(input int sel);
    case (sel)
      0: return b16.done;
      1: return b6.done;
      2: return b8.done;
      default: return b1.done;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0: return b16.busy;
      1: return b6.busy;
      2: return b8.busy;
      default: return b1.busy;
    endcase
  endfunction

  function automatic logic [63:0] get_bcd(input int sel);
    case (sel)
      0: return 64'(b16.bcd);
      1: return 64'(b6.bcd);
      2: return 64'(b8.bcd);
      default: return 64'(b1.bcd);
    endcase
  endfunction

  function automatic logic get_ovf(input int sel);
    case (sel)
      0: return b16.overflow;
      1: return b6.overflow;
      2: return b8.overflow;
      default: return b1.overflow;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the cycle where start is to be raised; returns in the done cycle (or on timeout).
  task automatic convert(input int sel, input longint unsigned v, input int poke_at,
                         input longint unsigned poke_v, output int lat, output int busy_n,
                         output logic [63:0] b, output logic o);
    drive(sel, 1'b1, v);
    tick();
    lat = 1;
    busy_n = 0;
    drive(sel, 1'b0, longint'($urandom));
    while (!get_done(sel) && lat < 200) begin
      if (get_busy(sel)) busy_n++;
      if (lat == poke_at) drive(sel, 1'b1, poke_v);
      else drive(sel, 1'b0, longint'($urandom));
      tick();
      lat++;
    end
    b = get_bcd(sel);
    o = get_ovf(sel);
  endtask

  task automatic conv_check(input int sel, input longint unsigned v, input int width,
                            input int digits);
    int lat, bn;
    logic [63:0] b, eb;
    logic o, eo;
    convert(sel, v, -1, 0, lat, bn, b, o);
    ref_bcd(v, digits, eb, eo);
    chk($sformatf("w%0d v=%0d latency", width, v), 64'(lat), 64'(width + 1));
    chk($sformatf("w%0d v=%0d busy_cycles", width, v), 64'(bn), 64'(width));
    chk($sformatf("w%0d v=%0d bcd", width, v), b, eb);
    chk($sformatf("w%0d v=%0d overflow", width, v), 64'(o), 64'(eo));
  endtask

  initial begin
    int lat, bn, cnt_done, cnt_busy;
    logic [63:0] b;
    logic o;

    for (int s = 0; s < 4; s++) drive(s, 1'b0, 0);
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("reset busy s%0d", s), 64'(get_busy(s)), 64'(0));
      chk($sformatf("reset done s%0d", s), 64'(get_done(s)), 64'(0));
      chk($sformatf("reset bcd s%0d", s), get_bcd(s), 64'(0));
      chk($sformatf("reset ovf s%0d", s), 64'(get_ovf(s)), 64'(0));
    end

    // Zero, then back-to-back full-scale and 12345 with start on the done cycle
    conv_check(0, 0, 16, 5);
    tick();
    conv_check(0, 65535, 16, 5);
    conv_check(0, 12345, 16, 5);

    // Start during a conversion is ignored and not queued
    tick();
    convert(0, 1234, 3, 9999, lat, bn, b, o);
    chk("ignored start latency", 64'(lat), 64'(17));
    chk("ignored start bcd", b, 64'h01234);
    chk("ignored start ovf", 64'(o), 64'(0));
    cnt_done = 0;
    cnt_busy = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (b16.done) cnt_done++;
      if (b16.busy) cnt_busy++;
    end
    chk("no second done", 64'(cnt_done), 64'(0));
    chk("no second busy", 64'(cnt_busy), 64'(0));
    chk("bcd held", 64'(b16.bcd), 64'h01234);

    // Reset mid-conversion aborts with no done
    drive(0, 1'b1, 777);
    tick();
    drive(0, 1'b0, 0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy", 64'(b16.busy), 64'(0));
    chk("abort done", 64'(b16.done), 64'(0));
    chk("abort bcd", 64'(b16.bcd), 64'(0));
    chk("abort ovf", 64'(b16.overflow), 64'(0));
    cnt_done = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (b16.done) cnt_done++;
    end
    chk("abort no done", 64'(cnt_done), 64'(0));
    conv_check(0, 42, 16, 5);

    // Random 16-bit values
    for (int i = 0; i < 25; i++) begin
      tick();
      conv_check(0, longint'($urandom_range(0, 65535)), 16, 5);
    end

    // Exhaustive 6-bit, 2 digits
    for (int v = 0; v < 64; v++) begin
      tick();
      conv_check(1, longint'(v), 6, 2);
    end

    // 8-bit with 2 digits: overflow then cleared by the next conversion
    tick();
    conv_check(2, 255, 8, 2);
    tick();
    conv_check(2, 99, 8, 2);
    for (int i = 0; i < 15; i++) begin
      tick();
      conv_check(2, longint'($urandom_range(0, 255)), 8, 2);
    end

    // Single-bit input, single digit
    tick();
    conv_check(3, 0, 1, 1);
    conv_check(3, 1, 1, 1);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
